sw_input_conditioner: RTL and testbench



---
 rtl/picoMIPS_pkg.sv | 11 +
 rtl/sync2ff.sv | 23 ++
 rtl/sw_input_conditioner.sv | 118 +++++++++++
 tb/tb_sw_input_conditioner.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/picoMIPS_pkg.sv
// Shared types for the picoMIPS input stage.
package picoMIPS_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } swin_state_t;

endpackage

// File: rtl/sync2ff.sv
// Two-flop synchroniser for asynchronous board inputs; clears to zero on reset.
module sync2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/sw_input_conditioner.sv
// Board switch front end: synchronises and debounces sw8, latches sws on each
// accepted press, and reports a one-cycle press event plus a press counter.
module sw_input_conditioner
  import picoMIPS_pkg::*;
#(
  parameter int unsigned n         = 8,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned PCW       = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sw8_raw,
  input  logic [n-1:0]   sws_raw,
  output logic           sw8_out,
  output logic [n-1:0]   sws_out,
  output logic           press_pulse,
  output logic [PCW-1:0] press_count
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic         sw8_s;
  logic [n-1:0] sws_s;

  swin_state_t    state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           sw8_nxt;
  logic [n-1:0]   sws_nxt;
  logic           pulse_nxt;
  logic [PCW-1:0] count_nxt;

  sync2ff #(.W(1)) u_sync_sw8 (
    .clk   (clk),
    .reset (reset),
    .d     (sw8_raw),
    .q     (sw8_s)
  );

  sync2ff #(.W(n)) u_sync_sws (
    .clk   (clk),
    .reset (reset),
    .d     (sws_raw),
    .q     (sws_s)
  );

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sw8_out     <= 1'b0;
      sws_out     <= '0;
      press_pulse <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sw8_out     <= sw8_nxt;
      sws_out     <= sws_nxt;
      press_pulse <= pulse_nxt;
      press_count <= count_nxt;
    end
  end

  // Debounce decisions; sw8_out follows the next state so it moves with the transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sws_nxt   = sws_out;
    pulse_nxt = 1'b0;
    count_nxt = press_count;

    case (state)
      IDLE: begin
        if (sw8_s) begin
          state_nxt = DEB_PRESS;
          cnt_nxt   = '0;
        end
      end
      DEB_PRESS: begin
        if (!sw8_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          sws_nxt   = sws_s;
          pulse_nxt = 1'b1;
          count_nxt = press_count + PCW'(1);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!sw8_s) begin
          state_nxt = DEB_RELEASE;
          cnt_nxt   = '0;
        end
      end
      DEB_RELEASE: begin
        if (sw8_s) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    sw8_nxt = (state_nxt == PRESSED) || (state_nxt == DEB_RELEASE);
  end

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner: per-edge vector table plus press/reset sequences.
module tb_sw_input_conditioner;

  localparam int unsigned N   = 8;
  localparam int unsigned DB  = 4;
  localparam int unsigned PCW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           sw8_raw = 1'b0;
  logic [N-1:0]   sws_raw = '0;
  logic           sw8_out;
  logic [N-1:0]   sws_out;
  logic           press_pulse;
  logic [PCW-1:0] press_count;

  int total = 0;
  int bad   = 0;

  sw_input_conditioner #(.n(N), .DB_CYCLES(DB), .PCW(PCW)) dut (
    .clk         (clk),
    .reset       (reset),
    .sw8_raw     (sw8_raw),
    .sws_raw     (sws_raw),
    .sw8_out     (sw8_out),
    .sws_out     (sws_out),
    .press_pulse (press_pulse),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  // One record per clock edge: inputs held before the edge, outputs expected after it.
  typedef struct {
    logic       rst;
    logic       sw8;
    logic [7:0] sws;
    logic       e_sw8;
    logic [7:0] e_sws;
    logic       e_p;
    logic [1:0] e_c;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic sw8, input logic [7:0] sws,
                     input logic e8, input logic [7:0] es, input logic ep,
                     input logic [1:0] ec, input int rep);
    vec_t v;
    v.rst = rst; v.sw8 = sw8; v.sws = sws;
    v.e_sw8 = e8; v.e_sws = es; v.e_p = ep; v.e_c = ec;
    for (int i = 0; i < rep; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s8, input logic [7:0] s);
    reset   = r;
    sw8_raw = s8;
    sws_raw = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int idx, input logic e8,
                         input logic [7:0] es, input logic ep, input logic [1:0] ec);
    chk({tag, ".sw8_out"},     idx, 32'(sw8_out),     32'(e8));
    chk({tag, ".sws_out"},     idx, 32'(sws_out),     32'(es));
    chk({tag, ".press_pulse"}, idx, 32'(press_pulse), 32'(ep));
    chk({tag, ".press_count"}, idx, 32'(press_count), 32'(ec));
  endtask

  // Full press then full release; sw8_out must rise and fall exactly 6 edges after the input.
  task automatic press(input logic [7:0] s, input logic [7:0] prev_sws,
                       input logic [1:0] prev_c, input logic [1:0] new_c);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, s);
      if (i < 6) chk_all("press", i, 1'b0, prev_sws, 1'b0, prev_c);
      else       chk_all("press", i, 1'b1, s, 1'b1, new_c);
    end
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, s);
      chk_all("release", i, (i < 6), s, 1'b0, new_c);
    end
  endtask

  initial begin
    // reset held with active inputs
    add(1, 1, 8'hFF, 0, 8'h00, 0, 0, 3);
    add(0, 0, 8'h06, 0, 8'h00, 0, 0, 1);
    // clean press: input rises before edge 4, output rises at edge 10
    add(0, 1, 8'h06, 0, 8'h00, 0, 0, 6);
    add(0, 1, 8'h06, 1, 8'h06, 1, 1, 1);
    add(0, 1, 8'h06, 1, 8'h06, 0, 1, 2);
    // release bounce: low 2, high 1, then low; sws change ignored
    add(0, 0, 8'h02, 1, 8'h06, 0, 1, 2);
    add(0, 1, 8'h02, 1, 8'h06, 0, 1, 1);
    add(0, 0, 8'h02, 1, 8'h06, 0, 1, 6);
    add(0, 0, 8'h02, 0, 8'h06, 0, 1, 1);
    // glitch of 3 cycles rejected
    add(0, 1, 8'h02, 0, 8'h06, 0, 1, 3);
    add(0, 0, 8'h02, 0, 8'h06, 0, 1, 4);
    // second press latches 8'h02
    add(0, 1, 8'h02, 0, 8'h06, 0, 1, 6);
    add(0, 1, 8'h02, 1, 8'h02, 1, 2, 1);
    add(0, 1, 8'h02, 1, 8'h02, 0, 2, 1);
    add(0, 0, 8'h02, 1, 8'h02, 0, 2, 6);
    add(0, 0, 8'h02, 0, 8'h02, 0, 2, 1);

    #1;
    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].sw8, vecs[k].sws);
      chk_all("vec", k, vecs[k].e_sw8, vecs[k].e_sws, vecs[k].e_p, vecs[k].e_c);
    end

    // count reaches 3, then wraps to 0
    press(8'h5A, 8'h02, 2'd2, 2'd3);
    press(8'hC3, 8'h5A, 2'd3, 2'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00);
      chk_all("idle", i, 1'b0, 8'hC3, 1'b0, 2'd0);
    end

    // reset while debouncing a press (cnt=2 after 5 edges with input high)
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h11);
      chk_all("mid", i, 1'b0, 8'hC3, 1'b0, 2'd0);
    end
    step(1'b1, 1'b1, 8'h11);
    chk_all("rst", 0, 1'b0, 8'h00, 1'b0, 2'd0);
    // with input still high, the press needs the full latency again
    press(8'h11, 8'h00, 2'd0, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
